// File: rtl/modular_multiplier_barrett_if.sv
// Operand/result handshake bundle for modular_multiplier_barrett.
// Carries prod_raw only when MODMUL_RAW_PRODUCT_EN is defined.
interface modular_multiplier_barrett_if #(
    parameter int unsigned W     = 30,
    parameter int unsigned TAG_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     c;
    logic [TAG_W-1:0] out_tag;
`ifdef MODMUL_RAW_PRODUCT_EN
    logic [2*W-1:0]   prod_raw;

    modport master (
        output in_valid, a, b, in_tag, out_ready,
        input  in_ready, out_valid, c, out_tag, prod_raw
    );
    modport slave (
        input  in_valid, a, b, in_tag, out_ready,
        output in_ready, out_valid, c, out_tag, prod_raw
    );
`else
    modport master (
        output in_valid, a, b, in_tag, out_ready,
        input  in_ready, out_valid, c, out_tag
    );
    modport slave (
        input  in_valid, a, b, in_tag, out_ready,
        output in_ready, out_valid, c, out_tag
    );
`endif
endinterface

// File: rtl/modular_multiplier_barrett.sv
// Six-stage pipelined c = (a*b) mod Q using Barrett reduction, valid/ready with global stall.
// Optional MODMUL_RAW_PRODUCT_EN adds the unreduced product prod_raw aligned with c.
module modular_multiplier_barrett #(
    parameter int unsigned     W     = 30,
    parameter longint unsigned Q     = 998244353,
    parameter int unsigned     TAG_W = 8
) (
    input logic                        clk,
    input logic                        rst_n,
    modular_multiplier_barrett_if.slave io_mm
);

    localparam logic [2*W:0] TWO_2W = (2*W+1)'(1) << (2*W);
    localparam logic [W:0]   MU     = (W+1)'(TWO_2W / (2*W+1)'(Q));
    localparam logic [W+1:0] Q_W2   = (W+2)'(Q);
    localparam logic [W:0]   Q_W1   = (W+1)'(Q);

    logic [6:1]       r_vld;
    logic [TAG_W-1:0] r_tag [1:6];
    logic [W-1:0]     r_a1;
    logic [W-1:0]     r_b1;
    logic [2*W-1:0]   r_p2;
    logic [W:0]       r_qhat3;
    logic [W+1:0]     r_plo3;
    logic [W+1:0]     r_r4;
    logic [W:0]       r_r15;
    logic [W-1:0]     r_c6;
`ifdef MODMUL_RAW_PRODUCT_EN
    logic [2*W-1:0]   r_raw [3:6];
`endif

    logic             w_stall;
    logic             w_adv;
    logic [2*W-1:0]   w_p;
    logic [3*W:0]     w_pmu;
    logic [W:0]       w_qhat;
    logic [W+1:0]     w_qq;
    logic [W+1:0]     w_r;
    logic [W+1:0]     w_r1;
    logic [W:0]       w_c;

    assign w_stall = r_vld[6] & ~io_mm.out_ready;
    assign w_adv   = ~w_stall;

    assign io_mm.in_ready  = w_adv;
    assign io_mm.out_valid = r_vld[6];
    assign io_mm.c         = r_c6;
    assign io_mm.out_tag   = r_tag[6];
`ifdef MODMUL_RAW_PRODUCT_EN
    assign io_mm.prod_raw  = r_raw[6];
`endif

    always_comb begin
        w_p    = {{W{1'b0}}, r_a1} * {{W{1'b0}}, r_b1};
        w_pmu  = {{(W+1){1'b0}}, r_p2} * {{(2*W){1'b0}}, MU};
        w_qhat = (W+1)'(w_pmu >> (2*W));
        // Only the low W+2 bits matter: the true remainder is below 3Q < 2^(W+2).
        w_qq   = {1'b0, r_qhat3} * Q_W2;
        w_r    = r_plo3 - w_qq;
        w_r1   = (r_r4 >= Q_W2) ? (r_r4 - Q_W2) : r_r4;
        w_c    = (r_r15 >= Q_W1) ? (r_r15 - Q_W1) : r_r15;
    end

    // Data registers load only behind a valid bit so c holds through bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld   <= '0;
            r_a1    <= '0;
            r_b1    <= '0;
            r_p2    <= '0;
            r_qhat3 <= '0;
            r_plo3  <= '0;
            r_r4    <= '0;
            r_r15   <= '0;
            r_c6    <= '0;
            for (int i = 1; i <= 6; i++) r_tag[i] <= '0;
`ifdef MODMUL_RAW_PRODUCT_EN
            for (int i = 3; i <= 6; i++) r_raw[i] <= '0;
`endif
        end else if (w_adv) begin
            r_vld <= {r_vld[5:1], io_mm.in_valid};
            if (io_mm.in_valid) begin
                r_a1     <= io_mm.a;
                r_b1     <= io_mm.b;
                r_tag[1] <= io_mm.in_tag;
            end
            for (int i = 2; i <= 6; i++) begin
                if (r_vld[i-1]) r_tag[i] <= r_tag[i-1];
            end
            if (r_vld[1]) r_p2 <= w_p;
            if (r_vld[2]) begin
                r_qhat3 <= w_qhat;
                r_plo3  <= r_p2[W+1:0];
            end
            if (r_vld[3]) r_r4  <= w_r;
            if (r_vld[4]) r_r15 <= (W+1)'(w_r1);
            if (r_vld[5]) r_c6  <= W'(w_c);
`ifdef MODMUL_RAW_PRODUCT_EN
            if (r_vld[2]) r_raw[3] <= r_p2;
            for (int i = 4; i <= 6; i++) begin
                if (r_vld[i-1]) r_raw[i] <= r_raw[i-1];
            end
`endif
        end
    end

endmodule

// File: tb/tb_modular_multiplier_barrett.sv
// Scoreboard bench for modular_multiplier_barrett: directed cases, stall, reset flush, random traffic.
module tb_modular_multiplier_barrett;

    localparam longint unsigned QM = 998244353;

    typedef struct {
        longint unsigned c;
        logic [7:0]      tag;
        longint unsigned raw;
        int              cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;
    int   cyc;
    bit   chk_lat;
    bit   rnd_on;
    exp_t sb[$];

    modular_multiplier_barrett_if #(.W(30), .TAG_W(8)) mm_if ();

    modular_multiplier_barrett #(.W(30), .Q(QM), .TAG_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io_mm (mm_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        longint unsigned av;
        longint unsigned bv;
        if (rst_n) begin
            if (mm_if.out_valid && mm_if.out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("c", mm_if.c, e.c);
                    chk("out_tag", mm_if.out_tag, e.tag);
                    chk("c_lt_q", (mm_if.c < QM) ? 1 : 0, 1);
                    if (chk_lat) chk("latency", cyc - e.cyc, 6);
`ifdef MODMUL_RAW_PRODUCT_EN
                    chk("prod_raw", mm_if.prod_raw, e.raw);
`endif
                end
            end
            if (mm_if.in_valid && mm_if.in_ready) begin
                av    = mm_if.a;
                bv    = mm_if.b;
                e.raw = av * bv;
                e.c   = e.raw % QM;
                e.tag = mm_if.in_tag;
                e.cyc = cyc;
                sb.push_back(e);
            end
        end
    end

    task automatic send(input logic [29:0] a, input logic [29:0] b, input logic [7:0] tag);
        bit acc;
        acc = 0;
        mm_if.in_valid = 1'b1;
        mm_if.a        = a;
        mm_if.b        = b;
        mm_if.in_tag   = tag;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (mm_if.in_ready) begin
                acc = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        mm_if.in_valid = 1'b0;
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 300; k++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0 && !mm_if.out_valid) break;
        end
        chk("drain_empty", sb.size(), 0);
        chk("drain_idle", mm_if.out_valid, 0);
    endtask

    initial begin
        logic [29:0] hold_c;
        logic [7:0]  hold_tag;
        bit          seen;
        n_chk = 0;
        n_err = 0;
        cyc   = 0;
        chk_lat = 1;
        rnd_on  = 0;
        rst_n = 1'b0;
        mm_if.in_valid  = 1'b0;
        mm_if.a         = '0;
        mm_if.b         = '0;
        mm_if.in_tag    = '0;
        mm_if.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", mm_if.out_valid, 0);
        chk("rst_c", mm_if.c, 0);
        chk("rst_out_tag", mm_if.out_tag, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", mm_if.in_ready, 1);
        @(posedge clk);
        #1;

        // 1: single op, latency 6
        send(30'd2, 30'd3, 8'h11);
        wait_drain();

        // 2: back-to-back operands at and around Q
        send(30'(QM - 1), 30'(QM - 1), 8'h21);
        send(30'(QM), 30'd5, 8'h22);
        send(30'(QM + 1), 30'd7, 8'h23);
        send(30'd0, 30'h3FFF_FFFF, 8'h24);
        wait_drain();

        // 3: stall for three cycles once output is valid
        chk_lat = 0;
        send(30'd123456, 30'd654321, 8'h31);
        send(30'h3FFF_FFFF, 30'h3FFF_FFFF, 8'h32);
        send(30'd999999999, 30'd2, 8'h33);
        send(30'd77, 30'd88, 8'h34);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            if (mm_if.out_valid) begin
                seen = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("stall_seen_valid", seen, 1);
        mm_if.out_ready = 1'b0;
        hold_c   = mm_if.c;
        hold_tag = mm_if.out_tag;
        repeat (3) begin
            @(negedge clk);
            chk("stall_in_ready", mm_if.in_ready, 0);
            chk("stall_c_hold", mm_if.c, hold_c);
            chk("stall_tag_hold", mm_if.out_tag, hold_tag);
            chk("stall_valid_hold", mm_if.out_valid, 1);
        end
        @(posedge clk);
        #1;
        mm_if.out_ready = 1'b1;
        wait_drain();
        chk_lat = 1;

        // 4: reset with three ops in flight
        send(30'd11, 30'd12, 8'h41);
        send(30'd13, 30'd14, 8'h42);
        send(30'd15, 30'd16, 8'h43);
        rst_n = 1'b0;
        #1;
        chk("inflight_rst_valid", mm_if.out_valid, 0);
        chk("inflight_rst_c", mm_if.c, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("no_stale", mm_if.out_valid, 0);
        end
        @(posedge clk);
        #1;
        send(30'd4, 30'd5, 8'h44);
        wait_drain();

        // 5: random traffic with random gaps and backpressure
        chk_lat = 0;
        rnd_on  = 1;
        fork
            begin
                logic [29:0] ra;
                logic [29:0] rb;
                for (int n = 0; n < 3000; n++) begin
                    ra = 30'($urandom_range(0, 32'h3FFF_FFFF));
                    rb = 30'($urandom_range(0, 32'h3FFF_FFFF));
                    if ($urandom_range(0, 15) == 0) ra = 30'h3FFF_FFFF;
                    if ($urandom_range(0, 15) == 0) rb = 30'(QM - 1);
                    send(ra, rb, 8'(n));
                    if ($urandom_range(0, 2) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                rnd_on = 0;
            end
            begin
                while (rnd_on) begin
                    @(posedge clk);
                    #1;
                    mm_if.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        mm_if.out_ready = 1'b1;
        wait_drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
